// File: rtl/seg7_scan_if.sv
// Digit-store write/load bus for the seg7_scan display scanner.
interface seg7_scan_if;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [4:0]  wr_data;
  logic        ld_en;
  logic [31:0] ld_val;

  modport master (output wr_en, wr_addr, wr_data, ld_en, ld_val);
  modport slave  (input  wr_en, wr_addr, wr_data, ld_en, ld_val);
endinterface

// File: rtl/seg7_scan.sv
// Eight-digit multiplexed 7-segment scanner with anti-ghost blanking gaps.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan #(
  parameter int unsigned CNTMAX  = 2499,
  parameter int unsigned GAP_CYC = 16
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        en,
  seg7_scan_if.slave  bus,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [7:0]  an,
  output logic        frame_done
);

  localparam int unsigned PRE_W = 20;
  localparam int unsigned GAP_W = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned N_DIG = 8;

  typedef enum logic {SHOW = 1'b0, GAP = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [PRE_W-1:0]      pre_q, pre_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [N_DIG-1:0][4:0] store_q, store_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic [7:0]            an_q, an_d;
  logic                  frame_done_q, frame_done_d;
  logic                  tick_c;
  logic                  gap_last_c;

  function automatic logic [6:0] hex_decode(input logic [3:0] n);
    case (n)
      4'h0: hex_decode = 7'h40;
      4'h1: hex_decode = 7'h79;
      4'h2: hex_decode = 7'h24;
      4'h3: hex_decode = 7'h30;
      4'h4: hex_decode = 7'h19;
      4'h5: hex_decode = 7'h12;
      4'h6: hex_decode = 7'h02;
      4'h7: hex_decode = 7'h78;
      4'h8: hex_decode = 7'h00;
      4'h9: hex_decode = 7'h10;
      4'hA: hex_decode = 7'h08;
      4'hB: hex_decode = 7'h03;
      4'hC: hex_decode = 7'h46;
      4'hD: hex_decode = 7'h21;
      4'hE: hex_decode = 7'h06;
      default: hex_decode = 7'h0E;
    endcase
  endfunction

  assign tick_c     = (pre_q == PRE_W'(CNTMAX));
  assign gap_last_c = (gap_q == GAP_W'(GAP_CYC - 1));

`ifdef SEG7_LZB_EN
  // Blank runs of all-zero digits counted down from the leftmost; digit 0 always shows.
  logic [N_DIG-1:0] blank_c;
  always_comb begin
    blank_c    = '0;
    blank_c[7] = (store_q[7] == 5'd0);
    for (int i = 6; i >= 1; i--) begin
      blank_c[i] = blank_c[i+1] && (store_q[i] == 5'd0);
    end
  end
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pre_d        = tick_c ? '0 : pre_q + PRE_W'(1);
    gap_d        = gap_q;
    store_d      = store_q;
    frame_done_d = 1'b0;
    seg_d        = 7'h7F;
    dp_d         = 1'b1;
    an_d         = 8'hFF;

    // Bulk load overrides a concurrent single-digit write.
    if (bus.ld_en) begin
      for (int i = 0; i < int'(N_DIG); i++) begin
        store_d[i] = {1'b0, bus.ld_val[4*i +: 4]};
      end
    end else if (bus.wr_en) begin
      store_d[bus.wr_addr] = bus.wr_data;
    end

    case (state_q)
      SHOW: begin
        if (tick_c) begin
          state_d = GAP;
          gap_d   = '0;
        end
      end
      GAP: begin
        if (gap_last_c) begin
          state_d      = SHOW;
          idx_d        = idx_q + IDX_W'(1);
          pre_d        = '0;
          gap_d        = '0;
          frame_done_d = (idx_q == IDX_W'(N_DIG - 1));
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      default: state_d = SHOW;
    endcase

    // Drive decoded from current state; a one-hot-low anode can never overlap another.
    if (en && (state_q == SHOW)) begin
      an_d  = ~(8'(1) << idx_q);
      seg_d = hex_decode(store_q[idx_q][3:0]);
      dp_d  = ~store_q[idx_q][4];
`ifdef SEG7_LZB_EN
      if (blank_c[idx_q]) seg_d = 7'h7F;
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= SHOW;
      idx_q        <= '0;
      pre_q        <= '0;
      gap_q        <= '0;
      store_q      <= '0;
      seg_q        <= 7'h7F;
      dp_q         <= 1'b1;
      an_q         <= 8'hFF;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pre_q        <= pre_d;
      gap_q        <= gap_d;
      store_q      <= store_d;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with CNTMAX=3, GAP_CYC=2 (6-cycle digit slot, 48-cycle frame).
module tb_seg7_scan;
  logic       clk = 1'b0;
  logic       rstn;
  logic       en;
  logic [6:0] seg;
  logic       dp;
  logic [7:0] an;
  logic       frame_done;

  seg7_scan_if bus ();

  seg7_scan #(.CNTMAX(3), .GAP_CYC(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .bus        (bus),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] SEGS [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                       7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  int n_tests = 0;
  int n_fail  = 0;
  int k       = 0;           // posedges since reset release
  logic [4:0] mdl [8];

  // Output after edge kk reflects scan slot t = kk-1: 4 SHOW cycles then 2 GAP cycles per digit.
  function automatic int exp_dig(input int kk);
    int t;
    t = kk - 1;
    if (t < 0 || (t % 6) >= 4) return -1;
    return (t / 6) % 8;
  endfunction

  function automatic logic [7:0] exp_an(input int kk);
    int d;
    d = exp_dig(kk);
    if (d < 0) return 8'hFF;
    return ~(8'(1) << d);
  endfunction

  function automatic logic [6:0] exp_seg(input int d);
`ifdef SEG7_LZB_EN
    bit blank;
    blank = (d > 0);
    for (int j = d; j < 8; j++) if (mdl[j] != 5'd0) blank = 1'b0;
    if (blank) return 7'h7F;
`endif
    return SEGS[mdl[d][3:0]];
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    k++;
  endtask

  task automatic wait_pos(input int d, input int p);
    for (int i = 0; i < 100; i++) begin
      if (k >= 1 && ((k - 1) % 6) == p && (((k - 1) / 6) % 8) == d) return;
      step();
    end
  endtask

  task automatic bulk_load(input logic [31:0] v);
    bus.ld_en = 1'b1; bus.ld_val = v;
    step();
    bus.ld_en = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = {1'b0, v[4*i +: 4]};
    step();
  endtask

  task automatic release_reset();
    @(negedge clk);
    rstn = 1'b1;
    k = 0;
    for (int i = 0; i < 8; i++) mdl[i] = 5'd0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b1;
    bus.wr_en = 1'b0; bus.wr_addr = '0; bus.wr_data = '0; bus.ld_en = 1'b0; bus.ld_val = '0;
    #22;
    n_tests++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: an=%h seg=%h dp=%b fd=%b, want an=ff seg=7f dp=1 fd=0", an, seg, dp, frame_done);
    end
    release_reset();
    step();
    n_tests++;
    if (an !== 8'hFE || seg !== 7'h40 || dp !== 1'b1) begin
      n_fail++;
      $display("FAIL first_show: an=%h seg=%h dp=%b, want an=fe seg=40 dp=1", an, seg, dp);
    end
  endtask

  task automatic test_walk();
    for (int i = 0; i < 53; i++) begin
      step();
      n_tests++;
      if (an !== exp_an(k) || frame_done !== (k % 48 == 0) ||
          (exp_dig(k) >= 0 && seg !== 7'h40) || (exp_dig(k) < 0 && seg !== 7'h7F)) begin
        n_fail++;
        $display("FAIL walk k=%0d: an=%h seg=%h fd=%b, want an=%h fd=%b", k, an, seg, frame_done,
                 exp_an(k), (k % 48 == 0));
      end
    end
  endtask

  task automatic check_frame(input string name);
    int pulses;
    pulses = 0;
    for (int i = 0; i < 48; i++) begin
      int d;
      d = exp_dig(k);
      n_tests++;
      if (an !== exp_an(k) || frame_done !== (k % 48 == 0) ||
          (d >= 0 && (seg !== exp_seg(d) || dp !== ~mdl[d][4])) || (d < 0 && (seg !== 7'h7F || dp !== 1'b1))) begin
        n_fail++;
        $display("FAIL %s k=%0d: an=%h seg=%h dp=%b fd=%b, want an=%h seg=%h", name, k, an, seg, dp,
                 frame_done, exp_an(k), (d >= 0) ? exp_seg(d) : 7'h7F);
      end
      if (frame_done === 1'b1) pulses++;
      step();
    end
    n_tests++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL %s_frame_done_count: got %0d pulses, want 1", name, pulses);
    end
  endtask

  task automatic test_bulk_load();
    bulk_load(32'h0123_89AF);
    check_frame("bulk_load");
  endtask

  task automatic test_write();
    wait_pos(2, 0);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 5'h15;
    step();
    bus.wr_en = 1'b0;
    mdl[2] = 5'h15;
    step();
    n_tests++;
    if (an !== 8'hFB || seg !== 7'h12 || dp !== 1'b0) begin
      n_fail++;
      $display("FAIL write_live: an=%h seg=%h dp=%b, want an=fb seg=12 dp=0", an, seg, dp);
    end
    wait_pos(2, 0);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd2; bus.wr_data = 5'h15;
    bus.ld_en = 1'b1; bus.ld_val = 32'h0;
    step();
    bus.wr_en = 1'b0; bus.ld_en = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = 5'd0;
    step();
    n_tests++;
    if (an !== 8'hFB || seg !== 7'h40 || dp !== 1'b1) begin
      n_fail++;
      $display("FAIL load_beats_write: an=%h seg=%h dp=%b, want an=fb seg=40 dp=1", an, seg, dp);
    end
  endtask

  task automatic test_back_to_back();
    wait_pos(3, 0);
    bus.wr_en = 1'b1; bus.wr_addr = 3'd3; bus.wr_data = 5'h07;
    step();
    bus.wr_data = 5'h1C;
    step();
    bus.wr_en = 1'b0;
    n_tests++;
    if (an !== 8'hF7 || seg !== 7'h78 || dp !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_first: an=%h seg=%h dp=%b, want an=f7 seg=78 dp=1", an, seg, dp);
    end
    step();
    mdl[3] = 5'h1C;
    n_tests++;
    if (an !== 8'hF7 || seg !== 7'h46 || dp !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_second: an=%h seg=%h dp=%b, want an=f7 seg=46 dp=0", an, seg, dp);
    end
  endtask

  task automatic test_enable();
    wait_pos(4, 0);
    en = 1'b0;
    step();
    n_tests++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
      n_fail++;
      $display("FAIL en_off: an=%h seg=%h dp=%b, want an=ff seg=7f dp=1", an, seg, dp);
    end
    step();
    en = 1'b1;
    step();
    n_tests++;
    if (an !== 8'hEF || seg !== exp_seg(4)) begin
      n_fail++;
      $display("FAIL en_resume: an=%h seg=%h, want an=ef seg=%h", an, seg, exp_seg(4));
    end
    en = 1'b0;
    begin
      int pulses;
      pulses = 0;
      for (int i = 0; i < 48; i++) begin
        step();
        if (frame_done === 1'b1) pulses++;
        n_tests++;
        if (an !== 8'hFF || frame_done !== (k % 48 == 0)) begin
          n_fail++;
          $display("FAIL en_dark k=%0d: an=%h fd=%b, want an=ff fd=%b", k, an, frame_done, (k % 48 == 0));
        end
      end
      n_tests++;
      if (pulses != 1) begin
        n_fail++;
        $display("FAIL en_dark_frame_done: got %0d pulses, want 1", pulses);
      end
    end
    en = 1'b1;
    step();
  endtask

  task automatic test_reset_mid_scan();
    bulk_load(32'h1111_1111);
    wait_pos(5, 1);
    rstn = 1'b0;
    #1;
    n_tests++;
    if (an !== 8'hFF || seg !== 7'h7F || frame_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_show: an=%h seg=%h fd=%b, want an=ff seg=7f fd=0", an, seg, frame_done);
    end
    release_reset();
    bulk_load(32'h2222_2222);
    wait_pos(5, 4);
    rstn = 1'b0;
    #1;
    n_tests++;
    if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_gap: an=%h seg=%h dp=%b, want an=ff seg=7f dp=1", an, seg, dp);
    end
    release_reset();
    for (int i = 0; i < 8; i++) begin
      step();
      n_tests++;
      if (an !== exp_an(k) || (exp_dig(k) >= 0 && seg !== 7'h40)) begin
        n_fail++;
        $display("FAIL reset_restart k=%0d: an=%h seg=%h, want an=%h seg=40", k, an, seg, exp_an(k));
      end
    end
  endtask

  task automatic test_lzb();
    bulk_load(32'h0000_0040);
    check_frame("lzb");
  endtask

  initial begin
    test_reset();
    test_walk();
    test_bulk_load();
    test_write();
    test_back_to_back();
    test_enable();
    test_reset_mid_scan();
    test_lzb();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 The block SHALL expose parameter CNTMAX, default 2499, the digit dwell prescaler terminal count (dwell = CNTMAX+1 clk cycles).
REQ-002 The block SHALL expose parameter GAP_CYC, default 16, the number of anti-ghost blanking clk cycles between digits (legal range 1..255).
REQ-003 The block SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-004 The block SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port en  input  1  display enable; low forces all digits dark.
REQ-006 The block SHALL have port wr_en  input  1  single-digit write strobe.
REQ-007 The block SHALL have port wr_addr  input  3  digit index for a single-digit write (0 = rightmost).
REQ-008 The block SHALL have port wr_data  input  5  {dp, hex nibble} for a single-digit write.
REQ-009 The block SHALL have port ld_en  input  1  bulk load strobe.
REQ-010 The block SHALL have port ld_val  input  32  eight hex nibbles for bulk load, [3:0] = digit 0.
REQ-011 The block SHALL have port seg  output  7  segments gfedcba, active-low.
REQ-012 The block SHALL have port dp  output  1  decimal point, active-low.
REQ-013 The block SHALL have port an  output  8  digit anodes, active-low, at most one bit low.
REQ-014 The block SHALL have port frame_done  output  1  one-cycle pulse per completed 8-digit frame.

Function
REQ-015 The block SHALL hold an 8-entry digit store of 5 bits each (dp, nibble); wr_en writes entry wr_addr, ld_en writes all nibbles and clears all dp bits, on the same clk edge.
REQ-016 When ld_en and wr_en are high in the same cycle, ld_en SHALL win and wr_en SHALL be ignored.
REQ-017 A 20-bit prescaler SHALL count 0..CNTMAX and wrap to 0; tick = (count == CNTMAX).
REQ-018 The scan FSM SHALL have states SHOW and GAP: SHOW --tick--> GAP; GAP counts GAP_CYC cycles, then advances digit index (7 wraps to 0), clears prescaler, returns to SHOW.
REQ-019 In SHOW, outputs SHALL be registered: an = ~(1 << idx), seg = decode(store[idx].nibble), dp = ~store[idx].dp.
REQ-020 In GAP, an SHALL be 8'hFF, seg 7'h7F, dp 1.
REQ-021 Decode SHALL be standard hex: 0->7'h40, 1->7'h79, 2->7'h24, 3->7'h30, 4->7'h19, 5->7'h12, 6->7'h02, 7->7'h78, 8->7'h00, 9->7'h10, A->7'h08, b->7'h03, C->7'h46, d->7'h21, E->7'h06, F->7'h0E.
REQ-022 A store write SHALL take effect on outputs one clk after the write edge if the written digit is currently in SHOW, else at its next SHOW.
REQ-023 frame_done SHALL pulse high for exactly one cycle on the GAP->SHOW transition into idx 0.
REQ-024 When en is low, an SHALL be 8'hFF, seg 7'h7F, dp 1 from the next clk; prescaler, FSM and frame_done SHALL continue unaffected.
REQ-025 The scan SHALL never drive two anodes low in any cycle, including across the en edge and a store write.

Reset
REQ-026 On rstn low, asynchronously: an=8'hFF, seg=7'h7F, dp=1, frame_done=0, state=SHOW, idx=0, prescaler=0, GAP counter=0, store all zero.
REQ-027 After rstn deasserts, the first SHOW SHALL display digit 0 starting on the first clk edge.
REQ-028 Reset asserted mid-GAP or mid-SHOW SHALL abort the scan with no residual anode drive.

Configuration
REQ-029 With macro SEG7_LZB_EN defined, leading-zero blanking SHALL apply: digits from 7 downward whose nibble is 0 and dp is 0, up to the first non-zero or dp digit, SHALL show seg 7'h7F (anode still scanned); digit 0 is never blanked.
REQ-030 Without SEG7_LZB_EN, all eight digits SHALL be decoded unconditionally and no blanking logic SHALL be present.

Verification (CNTMAX=3, GAP_CYC=2)
REQ-031 Reset release, store zero -> an walks FE,FF,FD,FF,...,7F,FF,FE; SHOW 4 cycles, GAP 2 cycles; seg 7'h40 each SHOW.
REQ-032 ld_val=32'h0123_89AF -> digit0 seg 7'h0E, digit1 7'h08, digit4 7'h30, digit7 7'h40; frame_done one cycle per 48-cycle frame.
REQ-033 wr_en with addr 2 data 5'h15 while digit 2 in SHOW -> next cycle seg 7'h12, dp 0; simultaneous ld_en=1 ld_val=0 -> seg 7'h40, dp 1.
REQ-034 en dropped mid-SHOW -> an 8'hFF next cycle; en raised -> display resumes at current idx with no double-low anode.
REQ-035 SEG7_LZB_EN, ld_val=32'h0000_0040 -> digits 7..2 seg 7'h7F, digit1 7'h19, digit0 7'h40; without macro digits 7..2 show 7'h40.
REQ-036 rstn asserted in GAP of digit 5 -> an 8'hFF immediately; after release, scan restarts at digit 0.
